// File: rtl/seg_pkg.sv
// Shared types and hex encoder for the seven-segment display controller.
// The per-digit blink bit is present only when SEG_BLINK_EN is defined.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef struct packed {
    logic       valid;
    logic [3:0] val;
    logic       dp;
`ifdef SEG_BLINK_EN
    logic       blink;
`endif
  } seg_entry_t;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_rr_arb.sv
// Round-robin arbiter: registered one-hot grant pulse, then one forced idle cycle
// so a requester can drop its request before it could be granted again.
module seg_rr_arb #(
  parameter int unsigned NReq = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [NReq-1:0] req_i,
  input  logic            hold_i,
  output logic [NReq-1:0] gnt_o
);

  localparam int unsigned PtrW = $clog2(NReq);

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] pick, scan;
  logic [NReq-1:0] gnt_q, gnt_d;
  logic            found;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    scan  = ptr_q;
    // Walk requesters starting at the pointer, wrapping at NReq-1.
    for (int unsigned k = 0; k < NReq; k++) begin
      if (!found && req_i[scan]) begin
        found = 1'b1;
        pick  = scan;
      end
      scan = (scan == PtrW'(NReq - 1)) ? '0 : scan + PtrW'(1);
    end

    gnt_d = '0;
    ptr_d = ptr_q;
    if (found && !hold_i && !(|gnt_q)) begin
      gnt_d[pick] = 1'b1;
      ptr_d       = (pick == PtrW'(NReq - 1)) ? '0 : pick + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gnt_q <= '0;
      ptr_q <= '0;
    end else begin
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
    end
  end

  assign gnt_o = gnt_q;

endmodule

// File: rtl/seg_disp_ctrl.sv
// Shared seven-segment controller: arbitrated writes into a digit buffer, scanned
// onto active-low anode/segment pins. Define SEG_BLINK_EN for per-digit blinking.
module seg_disp_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned NDIG      = 8,
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned BLINK_DIV = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*3-1:0] wr_dig,
  input  logic [NREQ*4-1:0] wr_val,
  input  logic [NREQ-1:0]   wr_dp,
`ifdef SEG_BLINK_EN
  input  logic [NREQ-1:0]   wr_blink,
`endif
  input  logic              clear,
  output logic [NREQ-1:0]   gnt,
  output logic [NDIG-1:0]   an_o,
  output logic [7:0]        seg_o
);

  localparam int unsigned IdxW = $clog2(NDIG);
  localparam int unsigned CntW = $clog2(SCAN_DIV);

  seg_entry_t            dbuf_q [NDIG];
  seg_entry_t            dbuf_d [NDIG];
  seg_entry_t            wr_entry, cur;
  logic                  wr_en;
  logic [IdxW-1:0]       wr_idx;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  cnt_wrap;
  logic [NDIG-1:0]       an_q, an_d;
  logic [7:0]            seg_q, seg_d;

  // Only the low IdxW bits of each digit index are meaningful.
  logic unused_wr_dig;
  assign unused_wr_dig = ^wr_dig;

  seg_rr_arb #(
    .NReq (NREQ)
  ) u_arb (
    .clk_i  (clk),
    .rst_ni (rst),
    .req_i  (req),
    .hold_i (clear),
    .gnt_o  (gnt)
  );

  // The granted requester's fields are captured at the edge closing its grant cycle.
  always_comb begin
    wr_en    = 1'b0;
    wr_idx   = '0;
    wr_entry = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        wr_en          = 1'b1;
        wr_idx         = wr_dig[3*i +: IdxW];
        wr_entry.valid = 1'b1;
        wr_entry.val   = wr_val[4*i +: 4];
        wr_entry.dp    = wr_dp[i];
`ifdef SEG_BLINK_EN
        wr_entry.blink = wr_blink[i];
`endif
      end
    end
  end

  always_comb begin
    dbuf_d = dbuf_q;
    if (clear) begin
      for (int unsigned i = 0; i < NDIG; i++) dbuf_d[i] = '0;
    end else if (wr_en) begin
      dbuf_d[wr_idx] = wr_entry;
    end
  end

  always_comb begin
    cnt_wrap = (cnt_q == CntW'(SCAN_DIV - 1));
    cnt_d    = cnt_wrap ? '0 : cnt_q + CntW'(1);
    idx_d    = cnt_wrap ? idx_q + IdxW'(1) : idx_q;
  end

`ifdef SEG_BLINK_EN
  localparam int unsigned FrmW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [FrmW-1:0] frm_q, frm_d;
  logic            phase_q, phase_d;
  logic            frame_done;

  // phase_q high means blink-flagged digits are shown.
  always_comb begin
    frame_done = cnt_wrap && (idx_q == IdxW'(NDIG - 1));
    frm_d      = frm_q;
    phase_d    = phase_q;
    if (clear) begin
      frm_d   = '0;
      phase_d = 1'b1;
    end else if (frame_done) begin
      if (frm_q == FrmW'(BLINK_DIV - 1)) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + FrmW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frm_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      frm_q   <= frm_d;
      phase_q <= phase_d;
    end
  end
`else
  logic unused_blink_div;
  assign unused_blink_div = (BLINK_DIV != 0);
`endif

  // Outputs are built from next-state values so anode and segments move together.
  always_comb begin
    cur   = dbuf_d[idx_d];
    seg_d = SEG_BLANK;
    if (cur.valid) seg_d = {~cur.dp, hex_to_seg(cur.val)};
`ifdef SEG_BLINK_EN
    if (cur.valid && cur.blink && !phase_d) seg_d = SEG_BLANK;
`endif
    an_d = ~(NDIG'(1) << idx_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NDIG; i++) dbuf_q[i] <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      an_q  <= {{(NDIG-1){1'b1}}, 1'b0};
      seg_q <= SEG_BLANK;
    end else begin
      dbuf_q <= dbuf_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Directed bench for seg_disp_ctrl (NREQ=4, NDIG=8, SCAN_DIV=4, BLINK_DIV=2).
// Blink scenario is compiled in only when SEG_BLINK_EN is defined.
module tb_seg_disp_ctrl;

  localparam int unsigned NREQ      = 4;
  localparam int unsigned NDIG      = 8;
  localparam int unsigned SCAN_DIV  = 4;
  localparam int unsigned BLINK_DIV = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*3-1:0] wr_dig = '0;
  logic [NREQ*4-1:0] wr_val = '0;
  logic [NREQ-1:0]   wr_dp = '0;
`ifdef SEG_BLINK_EN
  logic [NREQ-1:0]   wr_blink = '0;
`endif
  logic              clear = 1'b0;
  logic [NREQ-1:0]   gnt;
  logic [NDIG-1:0]   an_o;
  logic [7:0]        seg_o;

  int n_total = 0;
  int n_pass  = 0;

  seg_disp_ctrl #(
    .NREQ      (NREQ),
    .NDIG      (NDIG),
    .SCAN_DIV  (SCAN_DIV),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .wr_dig   (wr_dig),
    .wr_val   (wr_val),
    .wr_dp    (wr_dp),
`ifdef SEG_BLINK_EN
    .wr_blink (wr_blink),
`endif
    .clear    (clear),
    .gnt      (gnt),
    .an_o     (an_o),
    .seg_o    (seg_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_digit(input int d, output bit ok);
    logic [7:0] want;
    want = ~(8'(1) << d);
    ok   = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (an_o === want) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic set_wr(input int i, input int dig, input int val, input bit dp);
    wr_dig[3*i +: 3] = 3'(dig);
    wr_val[4*i +: 4] = 4'(val);
    wr_dp[i]         = dp;
  endtask

  // Leaves the bench just after release, aligned #1 after a rising edge.
  task automatic apply_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    req   = '0;
    clear = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #10;
    n_total++;
    if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b expected 0000", gnt);
    else n_pass++;
    n_total++;
    if (an_o !== 8'hFE) $display("FAIL reset_an: got %h expected fe", an_o);
    else n_pass++;
    n_total++;
    if (seg_o !== 8'hFF) $display("FAIL reset_seg: got %h expected ff", seg_o);
    else n_pass++;
    tick();
    rst = 1'b1;
    tick();
    tick();
    tick();
    n_total++;
    if (an_o !== 8'hFE) $display("FAIL scan_hold3: got %h expected fe", an_o);
    else n_pass++;
    tick();
    n_total++;
    if (an_o !== 8'hFD) $display("FAIL scan_step4: got %h expected fd", an_o);
    else n_pass++;
  endtask

  task automatic test_single();
    bit ok;
    apply_reset();
    set_wr(1, 0, 3, 1'b0);
    req = 4'b0010;
    tick();
    n_total++;
    if (gnt !== 4'b0010) $display("FAIL single_gnt: got %b expected 0010", gnt);
    else n_pass++;
    tick();
    n_total++;
    if (gnt !== 4'b0000) $display("FAIL single_idle: got %b expected 0000", gnt);
    else n_pass++;
    req = '0;
    wait_digit(0, ok);
    n_total++;
    if (!ok || seg_o !== 8'hB0) $display("FAIL single_seg: got %h (found %0d) expected b0", seg_o, ok);
    else n_pass++;
    wait_digit(1, ok);
    n_total++;
    if (!ok || seg_o !== 8'hFF) $display("FAIL empty_digit: got %h (found %0d) expected ff", seg_o, ok);
    else n_pass++;
  endtask

  task automatic test_all_four();
    logic [3:0] exp_g [8];
    logic [7:0] exp_s [4];
    bit ok;
    exp_g = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000};
    exp_s = '{8'h92, 8'h02, 8'hF8, 8'h00};
    apply_reset();
    for (int i = 0; i < 4; i++) set_wr(i, i, i + 5, i[0]);
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k > 0) req = req & ~exp_g[k-1];
      n_total++;
      if (gnt !== exp_g[k]) $display("FAIL all4_cycle%0d: got %b expected %b", k + 1, gnt, exp_g[k]);
      else n_pass++;
    end
    for (int d = 0; d < 4; d++) begin
      wait_digit(d, ok);
      n_total++;
      if (!ok || seg_o !== exp_s[d])
        $display("FAIL all4_digit%0d: got %h (found %0d) expected %h", d, seg_o, ok, exp_s[d]);
      else n_pass++;
    end
  endtask

  task automatic test_rr_order();
    bit ok;
    tick();
    set_wr(2, 5, 4'hA, 1'b0);
    req = 4'b0100;
    tick();
    n_total++;
    if (gnt !== 4'b0100) $display("FAIL rr_gnt2: got %b expected 0100", gnt);
    else n_pass++;
    tick();
    set_wr(0, 7, 4'hC, 1'b1);
    set_wr(3, 6, 4'hF, 1'b0);
    req = 4'b1001;
    tick();
    n_total++;
    if (gnt !== 4'b1000) $display("FAIL rr_3_first: got %b expected 1000", gnt);
    else n_pass++;
    tick();
    req[3] = 1'b0;
    tick();
    n_total++;
    if (gnt !== 4'b0001) $display("FAIL rr_0_second: got %b expected 0001", gnt);
    else n_pass++;
    tick();
    req = '0;
    wait_digit(5, ok);
    n_total++;
    if (!ok || seg_o !== 8'h88) $display("FAIL rr_digit5: got %h (found %0d) expected 88", seg_o, ok);
    else n_pass++;
    wait_digit(6, ok);
    n_total++;
    if (!ok || seg_o !== 8'h8E) $display("FAIL rr_digit6: got %h (found %0d) expected 8e", seg_o, ok);
    else n_pass++;
    wait_digit(7, ok);
    n_total++;
    if (!ok || seg_o !== 8'h46) $display("FAIL rr_digit7: got %h (found %0d) expected 46", seg_o, ok);
    else n_pass++;
  endtask

  task automatic test_clear();
    bit ok;
    tick();
    set_wr(0, 2, 1, 1'b0);
    req   = 4'b0001;
    clear = 1'b1;
    tick();
    n_total++;
    if (gnt !== 4'b0000) $display("FAIL clear_no_gnt: got %b expected 0000", gnt);
    else n_pass++;
    clear = 1'b0;
    tick();
    n_total++;
    if (gnt !== 4'b0001) $display("FAIL clear_then_gnt: got %b expected 0001", gnt);
    else n_pass++;
    tick();
    req = '0;
    wait_digit(0, ok);
    n_total++;
    if (!ok || seg_o !== 8'hFF) $display("FAIL clear_digit0: got %h (found %0d) expected ff", seg_o, ok);
    else n_pass++;
    wait_digit(2, ok);
    n_total++;
    if (!ok || seg_o !== 8'hF9) $display("FAIL clear_digit2: got %h (found %0d) expected f9", seg_o, ok);
    else n_pass++;
    wait_digit(3, ok);
    n_total++;
    if (!ok || seg_o !== 8'hFF) $display("FAIL clear_digit3: got %h (found %0d) expected ff", seg_o, ok);
    else n_pass++;
    wait_digit(5, ok);
    n_total++;
    if (!ok || seg_o !== 8'hFF) $display("FAIL clear_digit5: got %h (found %0d) expected ff", seg_o, ok);
    else n_pass++;
  endtask

  task automatic test_midreset();
    bit ok;
    tick();
    set_wr(1, 1, 4, 1'b0);
    req = 4'b0010;
    tick();
    n_total++;
    if (gnt !== 4'b0010) $display("FAIL midrst_gnt: got %b expected 0010", gnt);
    else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_total++;
    if (gnt !== 4'b0000) $display("FAIL midrst_gnt_lost: got %b expected 0000", gnt);
    else n_pass++;
    n_total++;
    if (an_o !== 8'hFE) $display("FAIL midrst_an: got %h expected fe", an_o);
    else n_pass++;
    n_total++;
    if (seg_o !== 8'hFF) $display("FAIL midrst_seg: got %h expected ff", seg_o);
    else n_pass++;
    req = '0;
    tick();
    rst = 1'b1;
    wait_digit(1, ok);
    n_total++;
    if (!ok || seg_o !== 8'hFF) $display("FAIL midrst_write_lost: got %h (found %0d) expected ff", seg_o, ok);
    else n_pass++;
    wait_digit(2, ok);
    n_total++;
    if (!ok || seg_o !== 8'hFF) $display("FAIL midrst_buf_cleared: got %h (found %0d) expected ff", seg_o, ok);
    else n_pass++;
  endtask

`ifdef SEG_BLINK_EN
  task automatic test_blink();
    logic [7:0] exp0 [6];
    bit ok;
    exp0 = '{8'hC0, 8'hFF, 8'hFF, 8'hC0, 8'hC0, 8'hFF};
    apply_reset();
    set_wr(0, 0, 0, 1'b0);
    set_wr(1, 1, 1, 1'b0);
    wr_blink = 4'b0001;
    req      = 4'b0011;
    tick();
    tick();
    req = 4'b0010;
    tick();
    tick();
    req = '0;
    wait_digit(2, ok);
    for (int f = 0; f < 6; f++) begin
      wait_digit(0, ok);
      n_total++;
      if (!ok || seg_o !== exp0[f])
        $display("FAIL blink_frame%0d: got %h (found %0d) expected %h", f + 1, seg_o, ok, exp0[f]);
      else n_pass++;
      wait_digit(1, ok);
      n_total++;
      if (!ok || seg_o !== 8'hF9)
        $display("FAIL steady_frame%0d: got %h (found %0d) expected f9", f + 1, seg_o, ok);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_rr_order();
    test_clear();
    test_midreset();
`ifdef SEG_BLINK_EN
    test_blink();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/seg_disp_ctrl.md
# seg_disp_ctrl

Shared seven-segment display controller. Arbitrates up to NREQ requesters (priority-encoder result, counters, debug) writing hex digits into an NDIG-entry digit buffer, and time-multiplexes that buffer onto the common segment/anode pins. Sits between the switch/encoder logic in `top` and the board's seven-segment outputs.

## Interface
Parameters:
- NREQ, 4, number of write requesters (2..8)
- NDIG, 8, number of display digits (power of 2, 2..8)
- SCAN_DIV, 1000, clocks per digit scan slot (>=2)
- BLINK_DIV, 64, scan frames per blink half-period (used only with SEG_BLINK_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester write request, level, held until granted
- wr_dig  in  NREQ*3  target digit index per requester (slice i = bits 3i+2:3i; only low log2(NDIG) bits used)
- wr_val  in  NREQ*4  hex value per requester
- wr_dp  in  NREQ  decimal point per requester
- wr_blink  in  NREQ  blink flag per requester (present only with SEG_BLINK_EN)
- clear  in  1  synchronous clear of whole buffer
- gnt  out  NREQ  one-hot grant pulse, registered
- an_o  out  NDIG  active-low one-hot digit select, registered
- seg_o  out  8  active-low segments {dp,g,f,e,d,c,b,a}, registered

## Operation
- Buffer entry: valid, val[3:0], dp (+ blink). Reset/clear: all valid=0.
- Arbitration: round-robin. Pointer = index after last granted; reset pointer = 0 (requester 0 highest).
- gnt[i] high exactly one cycle; requester's wr_* sampled at the edge ending the gnt cycle and written to buffer[wr_dig], valid=1.
- No grant in cycle immediately following a grant (max one grant per 2 cycles); requester drops req on that edge, so no double grant.
- clear=1: buffer cleared, no grant issued that cycle, pointer unchanged; pending reqs remain and are served after clear drops.
- Scan: counter 0..SCAN_DIV-1; on wrap, digit index advances, NDIG-1 wraps to 0.
- seg_o = encode(buffer[idx]) with dp; invalid entry -> 8'hFF. an_o = ~(1<<idx).
- Write to the currently scanned digit updates seg_o on the next cycle.

## Timing
- Reset: gnt=0, an_o=~1 (digit 0), seg_o=8'hFF, scan counter=0, index=0, pointer=0.
- req rising at edge N -> gnt high in cycle N+1 (one-cycle latency) if arbiter idle.
- Buffer write visible on seg_o one cycle after gnt cycle when digit scanned; worst case NDIG*SCAN_DIV+2 cycles.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); grants in flight are lost.
- an_o and seg_o change on the same edge; no glitch between them.

## Configuration
- SEG_BLINK_EN defined: wr_blink port and blink entry bit exist; frame counter toggles phase every BLINK_DIV completed frames (frame = NDIG digit slots); during off-phase, blink-flagged valid digits output 8'hFF. Phase=on at reset and on clear.
- Undefined: no wr_blink port, no blink logic; valid digits always displayed.

## Structure
- Package seg_pkg: hex-to-segment encode function (0..F, active-low), digit entry struct, SEG_BLANK=8'hFF constant.
- Sub-module seg_rr_arb: NREQ round-robin arbiter with one-cycle grant and post-grant idle cycle.

## Test plan
- Reset low with SCAN_DIV=4: gnt=0, an_o=8'hFE, seg_o=8'hFF; release, after 4 cycles an_o=8'hFD.
- req[1] with wr_dig=0, wr_val=3, wr_dp=0: gnt=4'b0010 one cycle later; when digit 0 scanned seg_o=8'hB0.
- All four req held from cycle 0: grants 0,1,2,3 in cycles 1,3,5,7; never two consecutive grant cycles.
- After grant to 2, req[0] and req[3] raised together: req 3 granted first.
- clear asserted in same cycle as req[0]: no grant that cycle, all digits 8'hFF; gnt[0] issued after clear drops.
- SEG_BLINK_EN, BLINK_DIV=2, digit 0 written val=0 blink=1: seg_o alternates 8'hC0 / 8'hFF every 2 frames; non-blink digit 1 steady.
